// File: rtl/block_transfer_sequencer_pkg.sv
// Shared types for the ARM block-transfer (LDM/STM) sequencer.
package arm_cpu_pkg;

   typedef enum logic [1:0] {
      IA = 2'b00,
      IB = 2'b01,
      DA = 2'b10,
      DB = 2'b11
   } addr_mode_t;

   typedef enum logic [1:0] {
      IDLE,
      TRANSFER,
      WRITEBACK,
      DONE
   } bt_state_t;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/block_transfer_sequencer_if.sv
// Word-beat data-memory bus with a valid/ready handshake.
interface block_transfer_sequencer_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  valid;
   logic                  ready;
   logic                  write;
   logic [DATA_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;

   modport master (
      output valid, write, addr, write_data,
      input  ready, read_data
   );

   modport slave (
      input  valid, write, addr, write_data,
      output ready, read_data
   );
endinterface

// File: rtl/block_transfer_sequencer_lsb_enc.sv
// Lowest-set-bit index, any-set flag and population count of a bit vector.
module lowest_set_bit_encoder #(
   parameter  int NUM_REGS = 16,
   localparam int IDX_W    = $clog2(NUM_REGS),
   localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
   input  logic [NUM_REGS-1:0] bits,
   output logic [IDX_W-1:0]    index,
   output logic                valid,
   output logic [CNT_W-1:0]    count
);
   always_comb begin
      index = '0;
      count = '0;
      valid = |bits;
      // Scan downwards so the last hit is the lowest set bit.
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (bits[i]) begin
            index = IDX_W'(i);
         end
         count = count + CNT_W'(bits[i]);
      end
   end
endmodule

// File: rtl/block_transfer_sequencer.sv
// LDM/STM sequencer: walks the register list low-to-high issuing word beats,
// then optionally writes back the updated base register.
module block_transfer_sequencer
   import arm_cpu_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int NUM_REGS   = 16,
   localparam int IDX_W      = $clog2(NUM_REGS),
   localparam int CNT_W      = $clog2(NUM_REGS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  is_load,
   input  logic [NUM_REGS-1:0]   reg_list,
   input  logic [1:0]            mode,
   input  logic                  writeback,
   input  logic [IDX_W-1:0]      base_reg,
   input  logic [DATA_WIDTH-1:0] base_value,
   output logic                  busy,
   output logic                  done,
   output logic [IDX_W-1:0]      reg_read_addr,
   input  logic [DATA_WIDTH-1:0] reg_read_data,
   output logic                  reg_write_enable,
   output logic [IDX_W-1:0]      reg_write_addr,
   output logic [DATA_WIDTH-1:0] reg_write_data,
   block_transfer_sequencer_if.master mem
);
   bt_state_t             state_reg, state_next;
   logic                  is_load_reg;
   logic                  wb_take_reg;
   addr_mode_t            mode_reg;
   logic [IDX_W-1:0]      base_reg_reg;
   logic [DATA_WIDTH-1:0] base_value_reg;
   logic [CNT_W-1:0]      count_reg;
   logic [NUM_REGS-1:0]   remain_reg;
   logic [DATA_WIDTH-1:0] addr_reg;

   logic [NUM_REGS-1:0]   enc_in;
   logic [IDX_W-1:0]      enc_index;
   logic                  enc_valid;
   logic [CNT_W-1:0]      enc_count;
   logic                  launch;
   logic                  handshake;
   logic [DATA_WIDTH-1:0] aligned_base;
   logic [DATA_WIDTH-1:0] start_span;
   logic [DATA_WIDTH-1:0] wb_span;
   logic [DATA_WIDTH-1:0] start_addr;

   // One encoder serves both jobs: popcount of the new list while idle,
   // next register of the remaining list while transferring.
   assign enc_in = (state_reg == IDLE) ? reg_list : remain_reg;

   lowest_set_bit_encoder #(.NUM_REGS(NUM_REGS)) u_enc (
      .bits  (enc_in),
      .index (enc_index),
      .valid (enc_valid),
      .count (enc_count)
   );

   assign launch       = (state_reg == IDLE) && start && enc_valid;
   assign handshake    = (state_reg == TRANSFER) && mem.ready;
   assign aligned_base = {base_value[DATA_WIDTH-1:2], 2'b00};
   assign start_span   = DATA_WIDTH'(enc_count) * DATA_WIDTH'(WORD_BYTES);
   assign wb_span      = DATA_WIDTH'(count_reg) * DATA_WIDTH'(WORD_BYTES);

   // Every mode starts at the lowest address so ascending registers map upwards.
   always_comb begin
      start_addr = aligned_base;
      case (addr_mode_t'(mode))
         IA: start_addr = aligned_base;
         IB: start_addr = aligned_base + DATA_WIDTH'(WORD_BYTES);
         DA: start_addr = aligned_base - start_span + DATA_WIDTH'(WORD_BYTES);
         DB: start_addr = aligned_base - start_span;
         default: start_addr = aligned_base;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         is_load_reg    <= 1'b0;
         wb_take_reg    <= 1'b0;
         mode_reg       <= IA;
         base_reg_reg   <= '0;
         base_value_reg <= '0;
         count_reg      <= '0;
         remain_reg     <= '0;
         addr_reg       <= '0;
      end else begin
         state_reg <= state_next;
         if (launch) begin
            is_load_reg    <= is_load;
            wb_take_reg    <= writeback && !(is_load && reg_list[base_reg]);
            mode_reg       <= addr_mode_t'(mode);
            base_reg_reg   <= base_reg;
            base_value_reg <= base_value;
            count_reg      <= enc_count;
            remain_reg     <= reg_list;
            addr_reg       <= start_addr;
         end else if (handshake) begin
            addr_reg   <= addr_reg + DATA_WIDTH'(WORD_BYTES);
            remain_reg <= remain_reg & (remain_reg - NUM_REGS'(1));
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      busy             = 1'b0;
      done             = 1'b0;
      reg_read_addr    = '0;
      reg_write_enable = 1'b0;
      reg_write_addr   = '0;
      reg_write_data   = '0;
      mem.valid        = 1'b0;
      mem.write        = 1'b0;
      mem.addr         = '0;
      mem.write_data   = '0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = enc_valid ? TRANSFER : DONE;
            end
         end
         TRANSFER: begin
            busy           = 1'b1;
            mem.valid      = 1'b1;
            mem.write      = !is_load_reg;
            mem.addr       = addr_reg;
            mem.write_data = reg_read_data;
            reg_read_addr  = enc_index;
            if (handshake && is_load_reg) begin
               reg_write_enable = 1'b1;
               reg_write_addr   = enc_index;
               reg_write_data   = mem.read_data;
            end
            if (handshake && enc_count == CNT_W'(1)) begin
               state_next = wb_take_reg ? WRITEBACK : DONE;
            end
         end
         WRITEBACK: begin
            busy             = 1'b1;
            reg_write_enable = 1'b1;
            reg_write_addr   = base_reg_reg;
            // Writeback uses the unaligned base, as the architecture defines.
            reg_write_data   = mode_reg[1] ? (base_value_reg - wb_span)
                                           : (base_value_reg + wb_span);
            state_next       = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule
